// File: rtl/ps2_led_commander.sv
// rtl/ps2_led_commander.sv - PS/2 host LED update sequencer (0xED + LED byte, ack collection, retry)
module ps2_led_commander #(
  parameter int TIMEOUT_CYCLES = 1_000_000,
  parameter int MAX_RETRIES    = 3
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic [2:0] led_state,
  input  logic       update,
  output logic [7:0] the_command,
  output logic       send_command,
  input  logic       command_was_sent,
  input  logic       error_communication_timed_out,
  input  logic [7:0] received_data,
  input  logic       received_data_en,
  output logic       rx_claim,
  output logic       busy,
  output logic       done,
  output logic       fail
);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam int RW = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRIES);
  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] RSP_ACK      = 8'hFA;
  localparam logic [7:0] RSP_RESEND   = 8'hFE;

  typedef enum logic [2:0] {
    S_IDLE, S_SEND_ED, S_WAIT_ACK1, S_SEND_LED, S_WAIT_ACK2, S_DONE, S_FAIL
  } state_t;

  state_t        state, next_state, retry_target;
  logic [7:0]    led_byte;
  logic [RW-1:0] retry_cnt;
  logic [TW-1:0] wait_cnt;
  logic          pending;
  logic          in_wait, got_ack, got_resend, timed_out, retry, start;
  logic [7:0]    cmd_d;
  logic          send_d, busy_d, done_d, fail_d;

  assign in_wait      = (state == S_WAIT_ACK1) || (state == S_WAIT_ACK2);
  assign got_ack      = in_wait && received_data_en && (received_data == RSP_ACK);
  assign got_resend   = in_wait && received_data_en && (received_data == RSP_RESEND);
  assign rx_claim     = got_ack || got_resend;
  assign timed_out    = in_wait && (wait_cnt == TO_LAST);
  assign start        = (state == S_IDLE) && (update || pending);
  assign retry_target = (retry_cnt < RETRY_MAX) ? S_SEND_ED : S_FAIL;

  always_ff @(posedge clk) begin
    if (!resetn) state <= S_IDLE;
    else         state <= next_state;
  end

  // An ack beats a timeout in the same cycle; a completed send beats a transmitter error.
  always_comb begin
    next_state = state;
    retry      = 1'b0;
    case (state)
      S_IDLE: if (update || pending) next_state = S_SEND_ED;
      S_SEND_ED, S_SEND_LED: begin
        if (command_was_sent)
          next_state = (state == S_SEND_ED) ? S_WAIT_ACK1 : S_WAIT_ACK2;
        else if (error_communication_timed_out)
          retry = 1'b1;
      end
      S_WAIT_ACK1, S_WAIT_ACK2: begin
        if (got_ack)
          next_state = (state == S_WAIT_ACK1) ? S_SEND_LED : S_DONE;
        else if (got_resend || timed_out)
          retry = 1'b1;
      end
      default: next_state = S_IDLE;
    endcase
    if (retry) next_state = retry_target;
  end

  always_comb begin
    send_d = (next_state == S_SEND_ED) || (next_state == S_SEND_LED);
    busy_d = (next_state != S_IDLE);
    done_d = (next_state == S_DONE);
    fail_d = (next_state == S_FAIL);
    cmd_d  = the_command;
    if (next_state == S_SEND_ED)       cmd_d = CMD_SET_LEDS;
    else if (next_state == S_SEND_LED) cmd_d = led_byte;
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      the_command  <= 8'h00;
      send_command <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      fail         <= 1'b0;
      led_byte     <= 8'h00;
      retry_cnt    <= '0;
      wait_cnt     <= '0;
      pending      <= 1'b0;
    end else begin
      the_command  <= cmd_d;
      send_command <= send_d;
      busy         <= busy_d;
      done         <= done_d;
      fail         <= fail_d;
      if (start) begin
        led_byte  <= {5'b00000, led_state};
        retry_cnt <= '0;
      end else if (retry && (retry_target == S_SEND_ED)) begin
        retry_cnt <= retry_cnt + 1'b1;
      end
      if (start)       pending <= 1'b0;
      else if (update) pending <= 1'b1;
      // Leaves the wait state at TO_LAST, so the counter cannot wrap.
      wait_cnt <= (in_wait && (next_state == state)) ? wait_cnt + 1'b1 : '0;
    end
  end
endmodule
